// File: rtl/spart_rx_pkg.sv
// Shared definitions for the SPART receiver: frame geometry, baud limits and FSM states.
package spart_rx_pkg;

  localparam int unsigned DATA_BITS      = 8;
  localparam int unsigned BIDX_W         = 3;
  localparam int unsigned BAUD_W         = 16;
  localparam logic [15:0] BAUD_MIN       = 16'd4;
  localparam logic [15:0] BAUD_RESET_DEF = 16'h0a2c;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Baud values below BAUD_MIN leave too few clocks to centre-sample a bit.
  function automatic logic baud_ok(input logic [BAUD_W-1:0] v);
    return v >= BAUD_MIN;
  endfunction

endpackage

// File: rtl/spart_rx_fifo.sv
// Show-ahead receive FIFO; head, flags and availability are all registered outputs.
module spart_rx_fifo
  import spart_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 rd,
  output logic                 full,
  output logic                 empty,
  output logic                 avail,
  output logic [DATA_BITS-1:0] dout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 full_q, empty_q, avail_q;
  logic                 do_wr, do_rd;

  // A full FIFO still accepts a write when the same cycle pops the head.
  always_comb begin
    do_wr    = wr && (!full_q || rd);
    do_rd    = rd && !empty_q;
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(do_wr) - CW'(do_rd);
    dout_d   = mem_q[rd_ptr_d];
    if (cnt_d == '0) begin
      dout_d = '0;
    end else if (do_wr && (wr_ptr_q == rd_ptr_d)) begin
      dout_d = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      avail_q  <= 1'b0;
    end else begin
      if (do_wr) mem_q[wr_ptr_q] <= din;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      full_q   <= (cnt_d == CW'(DEPTH));
      empty_q  <= (cnt_d == '0);
      avail_q  <= (cnt_d != '0);
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign avail = avail_q;
  assign dout  = dout_q;

endmodule

// File: rtl/spart_rx.sv
// SPART UART receiver (8N1, LSB first): synchroniser, start detect, bit FSM, FIFO, error flags.
module spart_rx
  import spart_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] BAUD_RESET  = BAUD_RESET_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  input  logic                 load_baud,
  input  logic [BAUD_W-1:0]    baud_val,
  input  logic                 rd,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 RDA,
  output logic                 FE,
  output logic                 OE
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs, rxs_prev_q, start_c;
  logic [BAUD_W-1:0]      baud_q;
  rx_state_e              state_q, state_d;
  logic [BAUD_W-1:0]      cnt_q, cnt_d;
  logic [BAUD_W-1:0]      bper_q, bper_d;
  logic [BIDX_W-1:0]      bidx_q, bidx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   push_c, fe_set_c, oe_set_c;
  logic                   fe_q, oe_q;
  logic                   fifo_full, fifo_empty, fifo_avail;

  // Synchroniser presets to idle-high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], RX};
      rxs_prev_q <= rxs;
    end
  end

  assign rxs     = sync_q[SYNC_STAGES-1];
  assign start_c = rxs_prev_q & ~rxs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_q <= BAUD_RESET;
    end else if (load_baud && baud_ok(baud_val)) begin
      baud_q <= baud_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bper_q  <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bper_q  <= bper_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
    end
  end

  // Bit timing: half a period to the start-bit centre, then full periods.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bper_d   = bper_q;
    bidx_d   = bidx_q;
    shift_d  = shift_q;
    push_c   = 1'b0;
    fe_set_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          bper_d  = baud_q;
          cnt_d   = baud_q >> 1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (!rxs) begin
            cnt_d   = bper_q - BAUD_W'(1);
            bidx_d  = '0;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          cnt_d   = bper_q - BAUD_W'(1);
          if (bidx_q == BIDX_W'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end else begin
            bidx_d = bidx_q + BIDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          push_c   = rxs;
          fe_set_c = ~rxs;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign oe_set_c = push_c & fifo_full & ~rd;

  // Sticky flags: a set in the same cycle as clr_err takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fe_q <= 1'b0;
      oe_q <= 1'b0;
    end else begin
      fe_q <= fe_set_c | (fe_q & ~clr_err);
      oe_q <= oe_set_c | (oe_q & ~clr_err);
    end
  end

  spart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst),
    .wr   (push_c),
    .din  (shift_q),
    .rd   (rd),
    .full (fifo_full),
    .empty(fifo_empty),
    .avail(fifo_avail),
    .dout (rx_data)
  );

  assign RDA = fifo_avail;
  assign FE  = fe_q;
  assign OE  = oe_q;

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: serial frames driven bit by bit, outputs sampled on the falling edge.
module tb_spart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RX = 1'b1;
  logic        load_baud = 1'b0;
  logic [15:0] baud_val = 16'd0;
  logic        rd = 1'b0;
  logic        clr_err = 1'b0;
  logic [7:0]  rx_data;
  logic        RDA, FE, OE;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spart_rx dut (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .load_baud(load_baud),
    .baud_val (baud_val),
    .rd       (rd),
    .clr_err  (clr_err),
    .rx_data  (rx_data),
    .RDA      (RDA),
    .FE       (FE),
    .OE       (OE)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_rda;
    logic [7:0] exp_data;
    logic       exp_fe;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame of b clocks per bit; the stop-bit sample cycle is 3+b/2+9b falling edges in.
  task automatic send(input logic [7:0] d, input logic stop, input int b, input int rd_at,
                      input int ld_at, input logic [15:0] ld_val,
                      output logic pre, output logic post);
    int push;
    int bit_n;
    push = 3 + b / 2 + 9 * b;
    pre  = 1'bx;
    post = 1'bx;
    for (int j = 0; j < 10 * b; j++) begin
      @(negedge clk);
      if (j == push) pre = RDA;
      if (j == push + 1) post = RDA;
      rd        = (j == rd_at);
      load_baud = (j == ld_at);
      baud_val  = ld_val;
      bit_n     = j / b;
      if (bit_n == 0) RX = 1'b0;
      else if (bit_n == 9) RX = stop;
      else RX = d[3'(bit_n - 1)];
    end
    @(negedge clk);
    rd        = 1'b0;
    load_baud = 1'b0;
  endtask

  task automatic send16(input logic [7:0] d);
    logic p, q;
    send(d, 1'b1, 16, -1, -1, 16'd0, p, q);
    RX = 1'b1;
    idle(8);
  endtask

  task automatic pop();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic clear();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic load(input logic [15:0] v);
    @(negedge clk);
    load_baud = 1'b1;
    baud_val  = v;
    @(negedge clk);
    load_baud = 1'b0;
  endtask

  vec_t vecs [6];

  initial begin
    logic pre, post;
    int   glitches;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};
    vecs[5] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0};

    idle(3);
    check("reset RDA", RDA, 0);
    check("reset rx_data", rx_data, 0);
    check("reset FE", FE, 0);
    check("reset OE", OE, 0);
    rst = 1'b1;
    load(16'd16);
    idle(5);

    // Single frames: exact push latency, data, framing error, empty-read behaviour
    foreach (vecs[i]) begin
      send(vecs[i].data, vecs[i].stop, 16, -1, -1, 16'd0, pre, post);
      RX = 1'b1;
      idle(20);
      check($sformatf("v%0d RDA before push", i), pre, 0);
      check($sformatf("v%0d RDA after push", i), post, vecs[i].exp_rda);
      check($sformatf("v%0d RDA", i), RDA, vecs[i].exp_rda);
      check($sformatf("v%0d rx_data", i), rx_data, vecs[i].exp_data);
      check($sformatf("v%0d FE", i), FE, vecs[i].exp_fe);
      pop();
      check($sformatf("v%0d RDA after rd", i), RDA, 0);
      check($sformatf("v%0d rx_data after rd", i), rx_data, 0);
      clear();
      check($sformatf("v%0d FE after clr", i), FE, 0);
    end

    // Overrun: fifth byte into a four-entry FIFO is dropped
    for (int k = 1; k <= 5; k++) begin
      send16(8'(k));
      check($sformatf("ovr OE after byte %0d", k), OE, (k == 5) ? 1 : 0);
    end
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovr head %0d", k), rx_data, k);
      pop();
    end
    check("ovr RDA drained", RDA, 0);
    clear();
    check("ovr OE cleared", OE, 0);

    // Framing error followed by a long break
    send(8'h3C, 1'b0, 16, -1, -1, 16'd0, pre, post);
    idle(20);
    check("brk FE", FE, 1);
    check("brk RDA", RDA, 0);
    clear();
    glitches = 0;
    repeat (640) begin
      @(negedge clk);
      if (FE !== 1'b0 || RDA !== 1'b0) glitches++;
    end
    check("brk quiet cycles", glitches, 0);
    RX = 1'b1;
    idle(40);
    send16(8'h55);
    check("brk rx_data", rx_data, 8'h55);
    check("brk FE after", FE, 0);
    pop();

    // Short low glitch is rejected at the start-bit centre
    @(negedge clk);
    RX = 1'b0;
    idle(6);
    RX = 1'b1;
    idle(40);
    check("glitch RDA", RDA, 0);
    check("glitch FE", FE, 0);
    send(8'h00, 1'b1, 16, -1, -1, 16'd0, pre, post);
    RX = 1'b1;
    idle(8);
    check("glitch pre", pre, 0);
    check("glitch post", post, 1);
    check("glitch rx_data", rx_data, 8'h00);
    check("glitch FE after", FE, 0);
    pop();

    // Push into a full FIFO in the same cycle as a pop
    for (int k = 0; k < 4; k++) send16(8'h11 + 8'(k));
    send(8'h77, 1'b1, 16, 155, -1, 16'd0, pre, post);
    RX = 1'b1;
    idle(8);
    check("full+rd OE", OE, 0);
    check("full+rd RDA", RDA, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("full+rd head %0d", k), rx_data, (k == 3) ? 8'h77 : 8'h12 + 8'(k));
      pop();
    end
    check("full+rd drained", RDA, 0);

    // Asynchronous reset in the middle of a frame
    send16(8'h99);
    send(8'h3C, 1'b0, 16, -1, -1, 16'd0, pre, post);
    RX = 1'b1;
    idle(8);
    check("pre-rst RDA", RDA, 1);
    check("pre-rst FE", FE, 1);
    @(negedge clk);
    RX = 1'b0;
    idle(60);
    rst = 1'b0;
    #1;
    check("rst RDA", RDA, 0);
    check("rst rx_data", rx_data, 0);
    check("rst FE", FE, 0);
    check("rst OE", OE, 0);
    @(negedge clk);
    RX = 1'b1;
    idle(3);
    rst = 1'b1;
    load(16'd16);
    load(16'd2);
    idle(5);
    send16(8'hC3);
    check("post-rst rx_data", rx_data, 8'hC3);
    check("post-rst FE", FE, 0);
    pop();

    // Baud change mid-frame applies to the next frame only
    send(8'h5A, 1'b1, 16, -1, 40, 16'd32, pre, post);
    RX = 1'b1;
    idle(8);
    check("baud old frame", rx_data, 8'h5A);
    pop();
    idle(8);
    send(8'h0F, 1'b1, 32, -1, -1, 16'd0, pre, post);
    RX = 1'b1;
    idle(8);
    check("baud new pre", pre, 0);
    check("baud new post", post, 1);
    check("baud new frame", rx_data, 8'h0F);
    check("baud new FE", FE, 0);
    pop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
